// File: rtl/jk_bank_driver.sv
// Drives J/K (and optionally preset/clear) of an external JK flip-flop bank until q_fb equals the captured target.
// Latency: done/err in the CHECK cycle, SETTLE+2 cycles after start on first-try success; retries add SETTLE+2 each.
// No backpressure: start is sampled only in IDLE and ignored while busy. Optional fallback macro: JK_FORCE_FALLBACK_EN.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] pr_set,
  output logic [WIDTH-1:0] pr_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef JK_FORCE_FALLBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_FORCE, S_CHECK2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] tgt_q;
  logic [3:0]       retry_cnt;
  logic [SW-1:0]    settle_cnt;
  logic             capture, retry_inc, done_c, err_c, match;
  logic [WIDTH-1:0] drv_tgt;
  logic             forced;

  assign match   = (q_fb == tgt_q);
  // Entering DRIVE straight from IDLE must use the incoming target, not the stale tgt_q.
  assign drv_tgt = capture ? target : tgt_q;

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    retry_inc = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture  = 1'b1;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE: state_nx = S_WAIT;
      S_WAIT: begin
        if (settle_cnt == '0) begin
`ifdef JK_FORCE_FALLBACK_EN
          state_nx = forced ? S_CHECK2 : S_CHECK;
`else
          state_nx = S_CHECK;
`endif
        end
      end
      S_CHECK: begin
        if (match) begin
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end else if (retry_cnt < 4'(MAX_RETRY)) begin
          retry_inc = 1'b1;
          state_nx  = S_DRIVE;
        end else begin
`ifdef JK_FORCE_FALLBACK_EN
          state_nx = S_FORCE;
`else
          err_c    = 1'b1;
          state_nx = S_IDLE;
`endif
        end
      end
`ifdef JK_FORCE_FALLBACK_EN
      S_FORCE: state_nx = S_WAIT;
      S_CHECK2: begin
        done_c   = match;
        err_c    = ~match;
        state_nx = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      tgt_q      <= '0;
      retry_cnt  <= '0;
      settle_cnt <= '0;
      j          <= '0;
      k          <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        tgt_q     <= target;
        retry_cnt <= '0;
      end else if (retry_inc) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
      if (state_nx == S_WAIT && state != S_WAIT)
        settle_cnt <= SW'(SETTLE - 1);
      else if (state == S_WAIT && settle_cnt != '0)
        settle_cnt <= settle_cnt - SW'(1);
      // Minimal-toggle excitation: only bits that differ get J or K, never both.
      if (state_nx == S_DRIVE) begin
        j <= ~q_fb & drv_tgt;
        k <= q_fb & ~drv_tgt;
      end else begin
        j <= '0;
        k <= '0;
      end
    end
  end

`ifdef JK_FORCE_FALLBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      forced <= 1'b0;
      pr_set <= '0;
      pr_clr <= '0;
    end else begin
      if (capture)
        forced <= 1'b0;
      else if (state_nx == S_FORCE)
        forced <= 1'b1;
      if (state_nx == S_FORCE) begin
        pr_set <= tgt_q & ~q_fb;
        pr_clr <= ~tgt_q & q_fb;
      end else begin
        pr_set <= '0;
        pr_clr <= '0;
      end
    end
  end
`else
  assign forced = 1'b0;
  assign pr_set = '0;
  assign pr_clr = '0;
`endif

  assign done = done_c;
  assign err  = err_c;
  assign busy = (state != S_IDLE) & ~done_c & ~err_c;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver driving a behavioural JK bank with optional stuck/ignore faults.
module tb_jk_bank_driver;

  localparam int W      = 4;
  localparam int SETTLE = 2;
  localparam int DONE_AT = SETTLE + 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] target;
  logic [W-1:0] q_fb;
  logic [W-1:0] j, k, pr_set, pr_clr;
  logic         busy, done, err;

  logic [W-1:0] bank_q, bank_val, stuck0, ign_jk;
  logic         bank_load;
  logic         inv_en;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .SETTLE(SETTLE), .MAX_RETRY(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .target(target), .q_fb(q_fb),
    .j(j), .k(k), .pr_set(pr_set), .pr_clr(pr_clr),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [W-1:0] bank_next(input logic [W-1:0] q, input logic [W-1:0] jj,
                                             input logic [W-1:0] kk, input logic [W-1:0] ps,
                                             input logic [W-1:0] pc, input logic [W-1:0] ign,
                                             input logic [W-1:0] st0);
    logic [W-1:0] n;
    n = q;
    for (int i = 0; i < W; i++) begin
      if (ps[i])       n[i] = 1'b1;
      else if (pc[i])  n[i] = 1'b0;
      else if (!ign[i]) begin
        case ({jj[i], kk[i]})
          2'b10:   n[i] = 1'b1;
          2'b01:   n[i] = 1'b0;
          2'b11:   n[i] = ~q[i];
          default: n[i] = q[i];
        endcase
      end
    end
    return n & ~st0;
  endfunction

  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else           bank_q <= bank_next(bank_q, j, k, pr_set, pr_clr, ign_jk, stuck0);
  end
  assign q_fb = bank_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (inv_en && reset_n) begin
      if ((j & k) != '0)           check("inv_j_and_k", 32'(j & k), 32'd0);
      if ((pr_set & pr_clr) != '0) check("inv_set_and_clr", 32'(pr_set & pr_clr), 32'd0);
      if (done && err)             check("inv_done_and_err", 32'(done & err), 32'd0);
    end
  end

  task automatic load_bank(input logic [W-1:0] v);
    @(negedge clk);
    bank_load = 1'b1;
    bank_val  = v;
    @(posedge clk);
    #1 bank_load = 1'b0;
  endtask

  // Runs one request; cycle 1 is the DRIVE cycle, counted at negedges after the accepting edge.
  task automatic run_op(input logic [W-1:0] tgt, input int bound,
                        output logic [W-1:0] jf, output logic [W-1:0] kf, output int drv_cnt,
                        output logic jbad, output int pr_cnt, output logic [W-1:0] ps_v,
                        output logic [W-1:0] pc_v, output int done_c, output int err_c,
                        output logic busy_at);
    jf = '0; kf = '0; drv_cnt = 0; jbad = 1'b0; pr_cnt = 0; ps_v = '0; pc_v = '0;
    done_c = -1; err_c = -1; busy_at = 1'b1;
    @(negedge clk);
    start  = 1'b1;
    target = tgt;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (c == 1) begin jf = j; kf = k; end
      if ((j | k) != '0) begin
        drv_cnt++;
        if (j != jf || k != kf) jbad = 1'b1;
      end
      if ((pr_set | pr_clr) != '0) begin
        pr_cnt++;
        ps_v = pr_set;
        pc_v = pr_clr;
      end
      if (done) done_c = c;
      if (err)  err_c  = c;
      if (done || err) begin
        busy_at = busy;
        break;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] q0;
    logic [W-1:0] tgt;
    logic [W-1:0] ej;
    logic [W-1:0] ek;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [W-1:0] jf, kf, psv, pcv;
    logic         jbad, busy_at;
    int           dc, pc, dn, er;

    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000};
    vecs[1] = '{4'b1111, 4'b0110, 4'b0000, 4'b1001};
    vecs[2] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1100, 4'b0011, 4'b0011, 4'b1100};
    vecs[4] = '{4'b1001, 4'b1111, 4'b0110, 4'b0000};
    vecs[5] = '{4'b0110, 4'b1001, 4'b1001, 4'b0110};

    reset_n = 1'b0; start = 1'b0; target = '0; inv_en = 1'b0;
    bank_load = 1'b1; bank_val = '0; stuck0 = '0; ign_jk = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {20'd0, j, k, pr_set}, 32'd0);
    check("reset_flags", {28'd0, pr_clr == '0, busy, done, err}, 32'h8);
    reset_n = 1'b1;
    bank_load = 1'b0;
    inv_en = 1'b1;

    // Ideal bank, one table entry per request.
    for (int v = 0; v < 6; v++) begin
      load_bank(vecs[v].q0);
      run_op(vecs[v].tgt, 40, jf, kf, dc, jbad, pc, psv, pcv, dn, er, busy_at);
      check($sformatf("vec%0d_j", v), 32'(jf), 32'(vecs[v].ej));
      check($sformatf("vec%0d_k", v), 32'(kf), 32'(vecs[v].ek));
      check($sformatf("vec%0d_done_cycle", v), 32'(dn), 32'(DONE_AT));
      check($sformatf("vec%0d_err", v), 32'(er), 32'hFFFF_FFFF);
      check($sformatf("vec%0d_busy_at_done", v), 32'(busy_at), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_bank_q", v), 32'(bank_q), 32'(vecs[v].tgt));
    end

    // Bit0 stuck at 0: four identical drive pulses, then failure.
    stuck0 = 4'b0001;
    load_bank(4'b0000);
    run_op(4'b0001, 60, jf, kf, dc, jbad, pc, psv, pcv, dn, er, busy_at);
    check("stuck_j", 32'(jf), 32'h1);
    check("stuck_drive_count", 32'(dc), 32'd4);
    check("stuck_drive_stable", 32'(jbad), 32'd0);
    check("stuck_done", 32'(dn), 32'hFFFF_FFFF);
    check("stuck_busy_at_err", 32'(busy_at), 32'd0);
`ifdef JK_FORCE_FALLBACK_EN
    check("stuck_err_cycle", 32'(er), 32'd20);
    check("stuck_force_count", 32'(pc), 32'd1);
    check("stuck_force_set", 32'(psv), 32'h1);
    check("stuck_force_clr", 32'(pcv), 32'h0);
`else
    check("stuck_err_cycle", 32'(er), 32'd16);
    check("stuck_no_force", 32'(pc), 32'd0);
`endif
    stuck0 = '0;

`ifdef JK_FORCE_FALLBACK_EN
    // Bit2 ignores J/K but honours preset: recovered by the force step.
    ign_jk = 4'b0100;
    load_bank(4'b0000);
    run_op(4'b0100, 60, jf, kf, dc, jbad, pc, psv, pcv, dn, er, busy_at);
    check("ign_drive_count", 32'(dc), 32'd4);
    check("ign_force_set", 32'(psv), 32'h4);
    check("ign_done_cycle", 32'(dn), 32'd20);
    check("ign_err", 32'(er), 32'hFFFF_FFFF);
    @(negedge clk);
    check("ign_bank_q", 32'(bank_q), 32'h4);
    ign_jk = '0;
`endif

    // start held high while busy with a different target must be ignored.
    load_bank(4'b0000);
    @(negedge clk);
    start = 1'b1; target = 4'b0011;
    @(posedge clk);
    #1 target = 4'b1100;
    begin
      int dcyc;
      dcyc = -1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 1) check("busy_start_j", 32'(j), 32'h3);
        if (c == 3) start = 1'b0;
        if (done) begin dcyc = c; break; end
      end
      check("busy_start_done_cycle", 32'(dcyc), 32'(DONE_AT));
      check("busy_start_bank_q", 32'(bank_q), 32'h3);
      @(negedge clk);
      @(negedge clk);
      check("busy_start_no_rerun", {31'd0, busy}, 32'd0);
    end

    // Async reset in DRIVE (j must clear at once) and in WAIT.
    load_bank(4'b0000);
    @(negedge clk);
    start = 1'b1; target = 4'b1111;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rst_drive_j_before", 32'(j), 32'hF);
    #1 reset_n = 1'b0;
    #1 check("rst_drive_j_after", 32'(j), 32'h0);
    check("rst_drive_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    load_bank(4'b0000);
    @(negedge clk);
    start = 1'b1; target = 4'b1001;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wait_busy_before", {31'd0, busy}, 32'd1);
    #1 reset_n = 1'b0;
    #1 check("rst_wait_outputs", {16'd0, j, k, pr_set, pr_clr}, 32'd0);
    check("rst_wait_flags", {29'd0, busy, done, err}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_stays_idle", {29'd0, busy, done, err}, 32'd0);

    inv_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
